multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives the existing datapath selects: RegDst, jal, ALUSrc, EXT, MemtoReg.
- Also drives write strobes, ALU opcode and next-PC select.
- Keeps cycle and retired-instruction counters for the bench.

---
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath: steps each instruction through
// FETCH/DECODE/EXE/MEM/WB, drives datapath selects and strobes, and counts cycles and retirements.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic             RegDst,
    output logic             jal,
    output logic             ALUSrc,
    output logic [1:0]       EXT,
    output logic             MemtoReg,
    output logic [2:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] FETCH  = 3'b000;
    localparam logic [2:0] DECODE = 3'b001;
    localparam logic [2:0] EXE    = 3'b010;
    localparam logic [2:0] MEM    = 3'b011;
    localparam logic [2:0] WB     = 3'b100;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, is_unknown;

    always_comb begin
        is_addu    = (opcode == 6'b000000) && (funct == 6'b100001);
        is_subu    = (opcode == 6'b000000) && (funct == 6'b100011);
        is_jr      = (opcode == 6'b000000) && (funct == 6'b001000);
        is_ori     = (opcode == 6'b001101);
        is_lw      = (opcode == 6'b100011);
        is_sw      = (opcode == 6'b101011);
        is_beq     = (opcode == 6'b000100);
        is_lui     = (opcode == 6'b001111);
        is_jal     = (opcode == 6'b000011);
        is_unknown = !(is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                       is_beq || is_lui || is_jal);
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (is_jal || is_jr || is_unknown) ? FETCH : EXE;
            EXE: begin
                if (is_beq)             state_d = FETCH;
                else if (is_lw || is_sw) state_d = MEM;
                else                    state_d = WB;
            end
            MEM:     state_d = is_sw ? FETCH : WB;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are computed raw here and gated by reset below.
    logic pc_wr_raw, ir_wr_raw, reg_wr_raw, mem_wr_raw;

    always_comb begin
        pc_wr_raw  = 1'b0;
        ir_wr_raw  = 1'b0;
        reg_wr_raw = 1'b0;
        mem_wr_raw = 1'b0;
        jal        = 1'b0;
        NPCOp      = 2'b00;
        case (state_q)
            FETCH: begin
                pc_wr_raw = 1'b1;
                ir_wr_raw = 1'b1;
            end
            DECODE: begin
                if (is_jal) begin
                    reg_wr_raw = 1'b1;
                    pc_wr_raw  = 1'b1;
                    jal        = 1'b1;
                    NPCOp      = 2'b10;
                end else if (is_jr) begin
                    pc_wr_raw = 1'b1;
                    NPCOp     = 2'b11;
                end
            end
            EXE: begin
                if (is_beq) begin
                    pc_wr_raw = zero;
                    NPCOp     = 2'b01;
                end
            end
            MEM:     mem_wr_raw = is_sw;
            WB:      reg_wr_raw = 1'b1;
            default: ;
        endcase
    end

    assign PCWr  = pc_wr_raw  & ~reset;
    assign IRWr  = ir_wr_raw  & ~reset;
    assign RegWr = reg_wr_raw & ~reset;
    assign MemWr = mem_wr_raw & ~reset;

    // Selects stay at zero in FETCH and hold per class for the rest of the instruction.
    logic active;
    assign active = (state_q == DECODE) || (state_q == EXE) || (state_q == MEM) ||
                    (state_q == WB);

    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        EXT      = 2'b00;
        MemtoReg = 1'b0;
        ALUOp    = 3'b000;
        if (active) begin
            if (is_addu) begin
                RegDst = 1'b1;
            end else if (is_subu) begin
                RegDst = 1'b1;
                ALUOp  = 3'b001;
            end else if (is_ori) begin
                EXT   = 2'b01;
                ALUOp = 3'b010;
            end else if (is_lui) begin
                EXT   = 2'b10;
                ALUOp = 3'b010;
            end else if (is_lw) begin
                ALUSrc   = 1'b1;
                MemtoReg = 1'b1;
            end else if (is_sw) begin
                ALUSrc = 1'b1;
            end else if (is_beq) begin
                ALUOp = 3'b001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if ((state_q != FETCH) && (state_d == FETCH)) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random instruction
// stream, checked every cycle against a per-class phase/strobe model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        PCWr, IRWr, RegWr, MemWr, RegDst, jal, ALUSrc, MemtoReg;
    logic [1:0]  EXT, NPCOp;
    logic [2:0]  ALUOp, state;
    logic [31:0] cycle_cnt, instr_cnt;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .RegDst    (RegDst),
        .jal       (jal),
        .ALUSrc    (ALUSrc),
        .EXT       (EXT),
        .MemtoReg  (MemtoReg),
        .ALUOp     (ALUOp),
        .NPCOp     (NPCOp),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_LUI = 7, C_JAL = 8, C_UNK = 9, C_NOP = 10;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] exp_cycles = 0;
    logic [31:0] exp_instr  = 0;

    // Phase sequence of each class, from its path through the instruction steps.
    function automatic int inst_len(input int cls);
        case (cls)
            C_ADDU, C_SUBU, C_ORI, C_LUI, C_SW: return 4;
            C_LW:                               return 5;
            C_BEQ:                              return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic logic [2:0] phase_state(input int cls, input int i);
        logic [2:0] seq [5];
        if (cls == C_LW)      seq = '{S_F, S_D, S_E, S_M, S_W};
        else if (cls == C_SW) seq = '{S_F, S_D, S_E, S_M, S_F};
        else                  seq = '{S_F, S_D, S_E, S_W, S_F};
        return seq[i];
    endfunction

    // {RegDst, ALUSrc, EXT, MemtoReg, ALUOp} held from DECODE onward.
    function automatic logic [7:0] sel_of(input int cls);
        case (cls)
            C_ADDU:  return {1'b1, 1'b0, 2'b00, 1'b0, 3'b000};
            C_SUBU:  return {1'b1, 1'b0, 2'b00, 1'b0, 3'b001};
            C_ORI:   return {1'b0, 1'b0, 2'b01, 1'b0, 3'b010};
            C_LUI:   return {1'b0, 1'b0, 2'b10, 1'b0, 3'b010};
            C_LW:    return {1'b0, 1'b1, 2'b00, 1'b1, 3'b000};
            C_SW:    return {1'b0, 1'b1, 2'b00, 1'b0, 3'b000};
            C_BEQ:   return {1'b0, 1'b0, 2'b00, 1'b0, 3'b001};
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_known(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h21) || (fn == 6'h23) || (fn == 6'h08);
        return (op == 6'h0D) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
               (op == 6'h0F) || (op == 6'h03);
    endfunction

    task automatic encode(input int cls, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (cls)
            C_ADDU: begin op = 6'h00; fn = 6'h21; end
            C_SUBU: begin op = 6'h00; fn = 6'h23; end
            C_JR:   begin op = 6'h00; fn = 6'h08; end
            C_ORI:  op = 6'h0D;
            C_LW:   op = 6'h23;
            C_SW:   op = 6'h2B;
            C_BEQ:  op = 6'h04;
            C_LUI:  op = 6'h0F;
            C_JAL:  op = 6'h03;
            C_NOP:  begin op = 6'h00; fn = 6'h00; end
            default: begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (is_known(op, fn));
            end
        endcase
    endtask

    // Drives one instruction (or its first nph phases) and checks every cycle.
    task automatic run_instr(input string tag, input int cls, input int nph, input logic zval);
        int          len;
        int          n;
        logic [5:0]  op_v, fn_v;
        logic [2:0]  st;
        logic        pcwr, irwr, regwr, memwr, jal_e;
        logic [1:0]  npc;
        logic [7:0]  sel;
        logic [14:0] exp_ctrl, got_ctrl;
        len = inst_len(cls);
        n   = (nph == 0) ? len : nph;
        encode(cls, op_v, fn_v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st = phase_state(cls, i);
            if (i == 0) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end else begin
                opcode = op_v;
                funct  = fn_v;
            end
            zero = (i == 2) ? zval : 1'($urandom);
            #1;
            {pcwr, irwr, regwr, memwr, jal_e} = 5'b0;
            npc = 2'b00;
            sel = (st == S_F) ? 8'h00 : sel_of(cls);
            case (st)
                S_F: begin pcwr = 1'b1; irwr = 1'b1; end
                S_D: begin
                    if (cls == C_JAL) begin regwr = 1; pcwr = 1; jal_e = 1; npc = 2'b10; end
                    if (cls == C_JR)  begin pcwr = 1; npc = 2'b11; end
                end
                S_E: if (cls == C_BEQ) begin pcwr = zval; npc = 2'b01; end
                S_M: memwr = (cls == C_SW);
                default: regwr = 1'b1;
            endcase
            exp_ctrl = {pcwr, irwr, regwr, memwr, sel[7], jal_e, sel[6], sel[5:4], sel[3],
                        sel[2:0], npc};
            got_ctrl = {PCWr, IRWr, RegWr, MemWr, RegDst, jal, ALUSrc, EXT, MemtoReg,
                        ALUOp, NPCOp};
            ntests++;
            if (state !== st) begin
                nfail++;
                $display("FAIL %s state cls=%0d ph=%0d: got %b want %b", tag, cls, i, state, st);
            end
            ntests++;
            if (got_ctrl !== exp_ctrl) begin
                nfail++;
                $display("FAIL %s ctrl cls=%0d ph=%0d: got %b want %b", tag, cls, i,
                         got_ctrl, exp_ctrl);
            end
            ntests++;
            if (cycle_cnt !== exp_cycles || instr_cnt !== exp_instr) begin
                nfail++;
                $display("FAIL %s counters cls=%0d ph=%0d: got %0d/%0d want %0d/%0d", tag, cls,
                         i, cycle_cnt, instr_cnt, exp_cycles, exp_instr);
            end
            @(posedge clk);
            #1;
            exp_cycles = exp_cycles + 1;
            if (i == len - 1) exp_instr = exp_instr + 1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'h0D;
        funct  = 6'h00;
        zero   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            ntests++;
            if (state !== S_F || {PCWr, IRWr, RegWr, MemWr} !== 4'b0 ||
                cycle_cnt !== 0 || instr_cnt !== 0) begin
                nfail++;
                $display("FAIL reset: got state %b strobes %b cnt %0d/%0d want 000 0000 0/0",
                         state, {PCWr, IRWr, RegWr, MemWr}, cycle_cnt, instr_cnt);
            end
            @(posedge clk);
        end
        #1;
        reset      = 1'b0;
        exp_cycles = 0;
        exp_instr  = 0;
    endtask

    task automatic test_ori();
        run_instr("ori", C_ORI, 0, 1'b0);
        ntests++;
        if (instr_cnt !== 1 || cycle_cnt !== 4) begin
            nfail++;
            $display("FAIL ori_retire: got %0d/%0d want 1/4", instr_cnt, cycle_cnt);
        end
    endtask

    task automatic test_lw_sw();
        run_instr("lw", C_LW, 0, 1'b0);
        run_instr("sw", C_SW, 0, 1'b1);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", C_BEQ, 0, 1'b1);
        run_instr("beq_not_taken", C_BEQ, 0, 1'b0);
    endtask

    task automatic test_jal_jr();
        run_instr("jal", C_JAL, 0, 1'b0);
        run_instr("jr", C_JR, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_instr("sw_pre_reset", C_SW, 3, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        ntests++;
        if (state !== S_M || {PCWr, IRWr, RegWr, MemWr} !== 4'b0) begin
            nfail++;
            $display("FAIL reset_mid_mem: got state %b strobes %b want 011 0000", state,
                     {PCWr, IRWr, RegWr, MemWr});
        end
        @(posedge clk);
        #1;
        reset      = 1'b0;
        exp_cycles = 0;
        exp_instr  = 0;
        ntests++;
        if (state !== S_F || cycle_cnt !== 0 || instr_cnt !== 0) begin
            nfail++;
            $display("FAIL reset_mid_after: got state %b cnt %0d/%0d want 000 0/0", state,
                     cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] c0, i0;
        c0 = exp_cycles;
        i0 = exp_instr;
        run_instr("stream_addu", C_ADDU, 0, 1'b0);
        run_instr("stream_subu", C_SUBU, 0, 1'b0);
        run_instr("stream_nop", C_NOP, 0, 1'b0);
        run_instr("stream_lui", C_LUI, 0, 1'b0);
        ntests++;
        if (instr_cnt !== i0 + 4 || cycle_cnt !== c0 + 14) begin
            nfail++;
            $display("FAIL stream_retire: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt,
                     i0 + 4, c0 + 14);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            run_instr("random", int'($urandom_range(0, 10)), 0, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_lw_sw();
        test_beq();
        test_jal_jr();
        test_reset_mid();
        test_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
